// File: rtl/instr_fetch_rom.sv
// rtl/instr_fetch_rom.sv - constant-ROM instruction fetch stage with valid/ready output
// Define FETCH_WRAP_EN to wrap the PC at the top of the ROM instead of halting there.
module instr_fetch_rom #(
    parameter int ADDR_W = 3,
    parameter int IMM_W  = 16,
    localparam int DATA_W = 9 + IMM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              instr_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] rom_word;
    logic              fetch;

    // Fixed program: load r2 1; load r1 1; add r2 r1; xor r2 r1; mov r7 r1; then NOPs.
    always_comb begin
        rom_word = '0;
        case (pc)
            ADDR_W'(0): rom_word = {3'b000, 3'b010, 3'b000, IMM_W'(1)};
            ADDR_W'(1): rom_word = {3'b000, 3'b001, 3'b000, IMM_W'(1)};
            ADDR_W'(2): rom_word = {3'b010, 3'b010, 3'b001, IMM_W'(0)};
            ADDR_W'(3): rom_word = {3'b011, 3'b010, 3'b001, IMM_W'(0)};
            ADDR_W'(4): rom_word = {3'b001, 3'b111, 3'b001, IMM_W'(0)};
            default:    rom_word = '0;
        endcase
    end

    assign fetch = enable && !halted && !jump_valid && (!instr_valid || instr_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            instr_valid <= 1'b0;
            instr_data  <= '0;
            instr_pc    <= '0;
        end else if (jump_valid) begin
            // A jump flushes the presented word; instr_data/instr_pc keep their last values.
            pc          <= jump_addr;
            instr_valid <= 1'b0;
        end else if (fetch) begin
            instr_data  <= rom_word;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
`ifdef FETCH_WRAP_EN
            pc          <= pc + ADDR_W'(1);
`else
            if (pc != LAST_ADDR) begin
                pc <= pc + ADDR_W'(1);
            end
`endif
        end else if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

`ifdef FETCH_WRAP_EN
    assign halted = 1'b0;
`else
    logic halted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else if (jump_valid) begin
            halted_q <= 1'b0;
        end else if (fetch && pc == LAST_ADDR) begin
            halted_q <= 1'b1;
        end
    end

    assign halted = halted_q;
`endif

endmodule

// File: tb/tb_instr_fetch_rom.sv
// tb/tb_instr_fetch_rom.sv - directed and randomized checks of instr_fetch_rom against a reference model
module tb_instr_fetch_rom;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        jump_valid;
    logic [2:0]  jump_addr;
    logic        instr_ready;
    logic        instr_valid;
    logic [24:0] instr_data;
    logic [2:0]  instr_pc;
    logic        halted;

    int tests = 0;
    int fails = 0;

    int rom [8] = '{32'h0100001, 32'h0080001, 32'h0910000, 32'h0D10000,
                    32'h0790000, 32'h0, 32'h0, 32'h0};
    int seq_data [5] = '{32'h0100001, 32'h0080001, 32'h0910000, 32'h0D10000, 32'h0790000};

    // Reference state: program counter, presented word and halt flag.
    int m_pc, m_valid, m_data, m_ipc, m_halted;

    instr_fetch_rom dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .jump_valid  (jump_valid),
        .jump_addr   (jump_addr),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"},  32'(instr_valid), m_valid);
        chk({tag, "_data"},   32'(instr_data),  m_data);
        chk({tag, "_pc"},     32'(instr_pc),    m_ipc);
        chk({tag, "_halted"}, 32'(halted),      m_halted);
    endtask

    task automatic model_reset();
        m_pc = 0; m_valid = 0; m_data = 0; m_ipc = 0; m_halted = 0;
    endtask

    // One clock: drive inputs, advance the model by the fetch rules, compare just after the edge.
    task automatic step(input logic en, input logic jv, input logic [2:0] ja, input logic rdy,
                        input string tag);
        bit do_fetch;
        enable = en; jump_valid = jv; jump_addr = ja; instr_ready = rdy;
        do_fetch = en && (m_halted == 0) && !jv && (m_valid == 0 || rdy);
        if (jv) begin
            m_pc = ja; m_valid = 0; m_halted = 0;
        end else if (do_fetch) begin
            m_data = rom[m_pc]; m_ipc = m_pc; m_valid = 1;
`ifdef FETCH_WRAP_EN
            m_pc = (m_pc + 1) % 8;
`else
            if (m_pc == 7) m_halted = 1;
            else           m_pc = m_pc + 1;
`endif
        end else if (m_valid == 1 && rdy) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; jump_valid = 1'b0; jump_addr = '0; instr_ready = 1'b0;
        model_reset();
        #12;
        chk("reset_valid",  32'(instr_valid), 0);
        chk("reset_data",   32'(instr_data),  0);
        chk("reset_pc",     32'(instr_pc),    0);
        chk("reset_halted", 32'(halted),      0);
        @(negedge clk);
        rst_n = 1'b1;

        // Straight-line program delivery with the consumer always ready.
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 1, "seq");
            chk("seq_const_data", 32'(instr_data), seq_data[i]);
            chk("seq_const_pc",   32'(instr_pc),   i);
            chk("seq_const_valid", 32'(instr_valid), 1);
        end

        // Back-pressure while the word at pc=2 is presented.
        do_reset();
        step(1, 0, 0, 1, "bp_fill");
        step(1, 0, 0, 1, "bp_fill");
        step(1, 0, 0, 1, "bp_fill");
        chk("bp_at2", 32'(instr_pc), 2);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, "bp_stall");
            chk("bp_hold_data", 32'(instr_data), 32'h0910000);
        end
        step(1, 0, 0, 1, "bp_release");
        chk("bp_next_pc", 32'(instr_pc), 3);

        // Jump while pc=1 is pending: flush, then the target word.
        do_reset();
        step(1, 0, 0, 1, "jmp_fill");
        step(1, 0, 0, 1, "jmp_fill");
        chk("jmp_pending_pc", 32'(instr_pc), 1);
        step(1, 1, 3'd4, 0, "jmp_flush");
        chk("jmp_flush_valid", 32'(instr_valid), 0);
        step(1, 0, 0, 1, "jmp_target");
        chk("jmp_target_pc", 32'(instr_pc), 4);
        chk("jmp_target_data", 32'(instr_data), 32'h0790000);

        // Jump and fetch in the same cycle: the jump wins.
        step(1, 1, 3'd2, 1, "jf_same");
        chk("jf_no_old_word", 32'(instr_valid), 0);
        step(1, 0, 0, 1, "jf_after");
        chk("jf_after_pc", 32'(instr_pc), 2);

        // Run off the end of the ROM.
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 0, 1, "end_run");
        chk("end_last_pc", 32'(instr_pc), 7);
        chk("end_last_data", 32'(instr_data), 0);
        step(1, 0, 0, 1, "end_after");
`ifdef FETCH_WRAP_EN
        chk("wrap_pc0", 32'(instr_pc), 0);
        chk("wrap_halted", 32'(halted), 0);
`else
        chk("halt_set", 32'(halted), 1);
        chk("halt_valid_drop", 32'(instr_valid), 0);
        step(1, 0, 0, 1, "halt_idle");
        step(1, 1, 3'd0, 1, "halt_jump");
        chk("halt_clear", 32'(halted), 0);
        step(1, 0, 0, 1, "halt_restart");
        chk("halt_restart_data", 32'(instr_data), 32'h0100001);
`endif

        // Asynchronous reset between edges while pc=3 is stalled.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, "ar_fill");
        step(1, 0, 0, 0, "ar_stall");
        chk("ar_stall_pc", 32'(instr_pc), 3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model("ar_async");
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 1, "ar_first");
        chk("ar_first_pc", 32'(instr_pc), 0);
        chk("ar_first_data", 32'(instr_data), 32'h0100001);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, ($urandom % 8) == 0, 3'($urandom_range(0, 7)),
                 ($urandom % 3) != 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
